// File: rtl/acc_cpu_if.sv
// Bus between the acc_cpu core and its ROM / switch / LED side.
// The CPU uses the slave modport; the ROM and board side use the master modport.
interface acc_cpu_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  localparam int IMM_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  logic                 en;
  logic [4+IMM_W-1:0]   data;
  logic [DATA_W-1:0]    switch;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    led;
  logic                 carry;
  logic                 halted;

  modport master (output en, data, switch, input addr, led, carry, halted);
  modport slave  (input en, data, switch, output addr, led, carry, halted);
endinterface

// File: rtl/acc_cpu.sv
// Two-register TD4-style accumulator CPU: one instruction per enabled clock, carry flag,
// conditional jump and a HALT state that only reset leaves.
module acc_cpu #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  acc_cpu_if.slave  bus
);
  localparam int IMM_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  // S_RUN: executes bus.data whenever en is high; S_HALT: all state frozen until reset
  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [DATA_W-1:0]   r_a, w_a_nxt;
  logic [DATA_W-1:0]   r_b, w_b_nxt;
  logic [DATA_W-1:0]   r_led, w_led_nxt;
  logic                r_carry, w_carry_nxt;

  logic [3:0]          w_op;
  logic [DATA_W-1:0]   w_imm_d;
  logic [ADDR_W-1:0]   w_imm_a;

  assign w_op    = bus.data[4+IMM_W-1 -: 4];
  assign w_imm_d = bus.data[DATA_W-1:0];
  assign w_imm_a = bus.data[ADDR_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_pc    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_led   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_led   <= w_led_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_led_nxt   = r_led;
    w_carry_nxt = r_carry;
    if (r_state == S_RUN && bus.en) begin
      w_pc_nxt    = r_pc + ADDR_W'(1);
      w_carry_nxt = 1'b0;
      case (w_op)
        4'b0000: {w_carry_nxt, w_a_nxt} = {1'b0, r_a} + {1'b0, w_imm_d};
        4'b0001: w_a_nxt = r_b;
        4'b0010: w_a_nxt = bus.switch;
        4'b0011: w_a_nxt = w_imm_d;
        4'b0100: w_b_nxt = r_a;
        4'b0101: {w_carry_nxt, w_b_nxt} = {1'b0, r_b} + {1'b0, w_imm_d};
        4'b0110: w_b_nxt = bus.switch;
        4'b0111: w_b_nxt = w_imm_d;
        // HALT keeps the PC on the HALT instruction and leaves carry untouched
        4'b1000: begin
          w_state_nxt = S_HALT;
          w_pc_nxt    = r_pc;
          w_carry_nxt = r_carry;
        end
        4'b1001: w_led_nxt = r_b;
        4'b1011: w_led_nxt = w_imm_d;
        4'b1110: if (!r_carry) w_pc_nxt = w_imm_a;
        4'b1111: w_pc_nxt = w_imm_a;
        default: ;
      endcase
    end
  end

  assign bus.addr   = r_pc;
  assign bus.led    = r_led;
  assign bus.carry  = r_carry;
  assign bus.halted = (r_state == S_HALT);
endmodule

// File: tb/tb_acc_cpu.sv
// Directed bench for acc_cpu: a 4/4 instance and an 8-bit data / 6-bit address instance,
// with expectations queued as each step is driven and checked after the executing edge.
module tb_acc_cpu;
  logic clk = 1'b0;
  logic rst4, rst8;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  acc_cpu_if #(.DATA_W(4), .ADDR_W(4)) b4 ();
  acc_cpu_if #(.DATA_W(8), .ADDR_W(6)) b8 ();

  acc_cpu #(.DATA_W(4), .ADDR_W(4)) dut4 (.i_clk(clk), .i_rst(rst4), .bus(b4));
  acc_cpu #(.DATA_W(8), .ADDR_W(6)) dut8 (.i_clk(clk), .i_rst(rst8), .bus(b8));

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  function automatic logic [7:0] observe(int sel);
    case (sel)
      0:  return {4'b0, b4.addr};
      1:  return {4'b0, dut4.r_a};
      2:  return {4'b0, dut4.r_b};
      3:  return {4'b0, b4.led};
      4:  return {7'b0, b4.carry};
      5:  return {7'b0, b4.halted};
      10: return {2'b0, b8.addr};
      11: return dut8.r_a;
      14: return {7'b0, b8.carry};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step4(input logic [3:0] op, input logic [3:0] imm);
    b4.data = {op, imm};
    b4.en   = 1'b1;
    @(posedge clk);
    #1;
    check_sb();
  endtask

  task automatic step8(input logic [3:0] op, input logic [7:0] imm);
    b8.data = {op, imm};
    b8.en   = 1'b1;
    @(posedge clk);
    #1;
    check_sb();
  endtask

  initial begin
    rst4 = 1'b1;
    rst8 = 1'b1;
    b4.en = 1'b1; b4.data = 8'h3A; b4.switch = 4'h0;
    b8.en = 1'b0; b8.data = 12'h000; b8.switch = 8'h00;

    // reset dominates an enabled MOV A,10
    expect_val("rst_addr", 0, 8'd0);
    expect_val("rst_a", 1, 8'd0);
    expect_val("rst_led", 3, 8'd0);
    expect_val("rst_carry", 4, 8'd0);
    expect_val("rst_halted", 5, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_sb();
    rst4 = 1'b0;

    expect_val("mov_a9", 1, 8'd9);
    step4(4'b0011, 4'd9);
    expect_val("add_a8_a", 1, 8'd1);
    expect_val("add_a8_c", 4, 8'd1);
    step4(4'b0000, 4'd8);
    expect_val("add_a1_a", 1, 8'd2);
    expect_val("add_a1_c", 4, 8'd0);
    expect_val("add_a1_pc", 0, 8'd3);
    step4(4'b0000, 4'd1);
    expect_val("jnc_taken", 0, 8'd5);
    step4(4'b1110, 4'd5);
    expect_val("jmp2", 0, 8'd2);
    step4(4'b1111, 4'd2);
    expect_val("add_a15_a", 1, 8'd1);
    expect_val("add_a15_c", 4, 8'd1);
    step4(4'b0000, 4'd15);
    expect_val("jnc_not_taken", 0, 8'd4);
    expect_val("jnc_clr_c", 4, 8'd0);
    step4(4'b1110, 4'd5);

    b4.switch = 4'hC;
    expect_val("in_b", 2, 8'hC);
    expect_val("in_b_led", 3, 8'd0);
    step4(4'b0110, 4'd0);
    b4.switch = 4'h5;
    expect_val("out_b", 3, 8'hC);
    step4(4'b1001, 4'd0);
    expect_val("out_imm", 3, 8'd3);
    step4(4'b1011, 4'd3);
    expect_val("jmp15", 0, 8'd15);
    step4(4'b1111, 4'd15);
    expect_val("wrap_pc", 0, 8'd0);
    step4(4'b1010, 4'd7);
    expect_val("add_b5_b", 2, 8'd1);
    expect_val("add_b5_c", 4, 8'd1);
    step4(4'b0101, 4'd5);

    for (int i = 0; i < 3; i++) begin
      b4.en   = 1'b0;
      b4.data = {4'b0000, 4'(i + 1)};
      @(posedge clk);
      #1;
    end
    expect_val("en0_addr", 0, 8'd1);
    expect_val("en0_a", 1, 8'd1);
    expect_val("en0_b", 2, 8'd1);
    expect_val("en0_led", 3, 8'd3);
    expect_val("en0_c", 4, 8'd1);
    check_sb();

    expect_val("halt_flag", 5, 8'd1);
    expect_val("halt_pc", 0, 8'd1);
    step4(4'b1000, 4'd0);
    for (int i = 0; i < 10; i++) begin
      b4.en   = 1'($urandom_range(0, 1));
      b4.data = 8'($urandom);
      @(posedge clk);
      #1;
      expect_val("halt_hold_pc", 0, 8'd1);
      expect_val("halt_hold_flag", 5, 8'd1);
      expect_val("halt_hold_c", 4, 8'd1);
      expect_val("halt_hold_led", 3, 8'd3);
      check_sb();
    end
    rst4 = 1'b1;
    #1;
    expect_val("halt_rst_pc", 0, 8'd0);
    expect_val("halt_rst_flag", 5, 8'd0);
    check_sb();
    rst4 = 1'b0;
    b4.en = 1'b0;

    @(posedge clk);
    #1;
    rst8 = 1'b0;
    expect_val("w8_jmp63", 10, 8'd63);
    step8(4'b1111, 8'd63);
    expect_val("w8_wrap", 10, 8'd0);
    step8(4'b1100, 8'd0);
    expect_val("w8_jmp_ff", 10, 8'd63);
    step8(4'b1111, 8'hFF);
    expect_val("w8_mov200", 11, 8'd200);
    step8(4'b0011, 8'd200);
    expect_val("w8_add_a", 11, 8'd44);
    expect_val("w8_add_c", 14, 8'd1);
    step8(4'b0000, 8'd100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
